// File: rtl/conv_pkg.sv
// Shared widths, defaults and sample types for the conv/pool pipeline.
package conv_pkg;

  localparam int DEF_IN_W      = 18;
  localparam int DEF_OUT_W     = 8;
  localparam int DEF_FRAME_LEN = 5;
  localparam int DEF_POOL      = 2;
  localparam int DEF_SHIFT     = 4;

  localparam int N_OUT_PER_FRAME =
    (DEF_FRAME_LEN + DEF_POOL - 1) / DEF_POOL;

  typedef logic signed [DEF_IN_W-1:0]  y_t;
  typedef logic signed [DEF_OUT_W-1:0] x_t;

endpackage

// File: rtl/conv_pool_requant_if.sv
// y-in / x-out valid-ready stream pair of the pool/requant stage.
// master: upstream/downstream side; slave: the stage itself.
interface conv_pool_requant_if
  import conv_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
);

  logic signed [IN_W-1:0]  s_data_in_y;
  logic                    s_valid_y;
  logic                    s_ready_y;
  logic signed [OUT_W-1:0] m_data_out_x;
  logic                    m_valid_x;
  logic                    m_ready_x;

  modport master (
    output s_data_in_y, s_valid_y, m_ready_x,
    input  s_ready_y, m_data_out_x, m_valid_x
  );

  modport slave (
    input  s_data_in_y, s_valid_y, m_ready_x,
    output s_ready_y, m_data_out_x, m_valid_x
  );

endinterface

// File: rtl/requant_sat.sv
// Optional ReLU, floor shift and saturation IN_W -> OUT_W.
// ReLU clamp enabled by defining CONV_POOL_RELU_EN.
module requant_sat #(
  parameter int IN_W  = 18,
  parameter int OUT_W = 8,
  parameter int SHIFT = 4
) (
  input  logic signed [IN_W-1:0]  d,
  output logic signed [OUT_W-1:0] q
);

  localparam logic signed [IN_W-1:0] HI =
    IN_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [IN_W-1:0] LO =
    IN_W'(-(2 ** (OUT_W - 1)));

  logic signed [IN_W-1:0] r;
  logic signed [IN_W-1:0] v;

  always_comb begin
`ifdef CONV_POOL_RELU_EN
    r = d[IN_W-1] ? '0 : d;
`else
    r = d;
`endif
    v = r >>> SHIFT;
    if (v > HI)
      q = HI[OUT_W-1:0];
    else if (v < LO)
      q = LO[OUT_W-1:0];
    else
      q = v[OUT_W-1:0];
  end

endmodule

// File: rtl/conv_pool_requant.sv
// Frame-aware max-pool of the y stream, requantized to x.
// Define CONV_POOL_RELU_EN to clamp pooled maxima at zero.
module conv_pool_requant
  import conv_pkg::*;
#(
  parameter int IN_W      = DEF_IN_W,
  parameter int OUT_W     = DEF_OUT_W,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int POOL      = DEF_POOL,
  parameter int SHIFT     = DEF_SHIFT
) (
  input logic clk,
  input logic reset,
  conv_pool_requant_if.slave bus
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] WIN_LAST = CW'(POOL - 1);
  localparam logic [CW-1:0] FRM_LAST = CW'(FRAME_LEN - 1);

  logic [CW-1:0]           win_cnt;
  logic [CW-1:0]           frm_cnt;
  logic signed [IN_W-1:0]  max_q;
  logic signed [IN_W-1:0]  max_nx;
  logic signed [OUT_W-1:0] rq;
  logic                    acc;
  logic                    frm_end;
  logic                    close;

  assign bus.s_ready_y = !bus.m_valid_x || bus.m_ready_x;
  assign acc     = bus.s_valid_y && bus.s_ready_y;
  assign frm_end = frm_cnt == FRM_LAST;
  // frame end also closes a short trailing window
  assign close   = frm_end || (win_cnt == WIN_LAST);

  assign max_nx =
    (win_cnt == '0 || bus.s_data_in_y > max_q) ?
    bus.s_data_in_y : max_q;

  requant_sat #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_rq (
    .d (max_nx),
    .q (rq)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_cnt          <= '0;
      frm_cnt          <= '0;
      max_q            <= '0;
      bus.m_data_out_x <= '0;
      bus.m_valid_x    <= 1'b0;
    end else begin
      if (acc) begin
        max_q   <= max_nx;
        win_cnt <= close ? '0 : win_cnt + CW'(1);
        frm_cnt <= frm_end ? '0 : frm_cnt + CW'(1);
      end
      if (acc && close) begin
        bus.m_data_out_x <= rq;
        bus.m_valid_x    <= 1'b1;
      end else if (bus.m_ready_x) begin
        bus.m_valid_x <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_pool_requant.sv
// Directed bench for conv_pool_requant: SHIFT=5 and SHIFT=0 instances.
module tb_conv_pool_requant;
  import conv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  conv_pool_requant_if #(.IN_W(18), .OUT_W(8)) b5 ();
  conv_pool_requant_if #(.IN_W(18), .OUT_W(8)) b0 ();

  conv_pool_requant #(
    .IN_W(18), .OUT_W(8), .FRAME_LEN(5), .POOL(2), .SHIFT(5)
  ) u5 (
    .clk   (clk),
    .reset (reset),
    .bus   (b5.slave)
  );

  conv_pool_requant #(
    .IN_W(18), .OUT_W(8), .FRAME_LEN(5), .POOL(2), .SHIFT(0)
  ) u0 (
    .clk   (clk),
    .reset (reset),
    .bus   (b0.slave)
  );

  int   n_vec = 0;
  int   n_bad = 0;
  int   q5[$];
  int   q0[$];
  bit   rnd = 1'b0;
  logic rdy_fix = 1'b1;
  bit   hold5 = 1'b0;
  x_t   held5;

  y_t f1[5] = '{-2800, 3600, 400, 1600, 2800};
  y_t f2[5] = '{400, 6000, -2000, 2200, 600};
  y_t f3[5] = '{-2800, -3600, -5000, -4000, -100};
  y_t f4[5] = '{-5000, -6000, -7000, -8000, -9000};
  y_t f4b[5] = '{200, 100, 50, -3, 5};

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    #2;
    b5.m_ready_x = rnd ? 1'($urandom_range(0, 1)) : rdy_fix;
    b0.m_ready_x = b5.m_ready_x;
  end

  always @(negedge clk) begin
    if (b5.m_valid_x && b5.m_ready_x) q5.push_back(b5.m_data_out_x);
    if (b0.m_valid_x && b0.m_ready_x) q0.push_back(b0.m_data_out_x);
    if (hold5 && b5.m_valid_x)
      chk("hold_data", b5.m_data_out_x, held5);
    if (b5.m_valid_x && !b5.m_ready_x)
      chk("stall_sready", b5.s_ready_y, 0);
    hold5 = b5.m_valid_x && !b5.m_ready_x;
    held5 = b5.m_data_out_x;
  end

  task automatic send(input int sel, input y_t v, input int gap);
    int t = 0;
    if (sel == 0) begin
      b5.s_valid_y = 1'b0; b5.s_data_in_y = 'x;
    end else begin
      b0.s_valid_y = 1'b0; b0.s_data_in_y = 'x;
    end
    repeat (gap) begin @(posedge clk); #1; end
    if (sel == 0) begin
      b5.s_valid_y = 1'b1; b5.s_data_in_y = v;
    end else begin
      b0.s_valid_y = 1'b1; b0.s_data_in_y = v;
    end
    @(negedge clk);
    while (!((sel == 0) ? b5.s_ready_y : b0.s_ready_y) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_vec++;
      n_bad++;
      $error("FAIL send_timeout observed=%0d expected=<200", t);
    end else begin
      @(posedge clk); #1;
    end
    if (sel == 0) b5.s_valid_y = 1'b0;
    else          b0.s_valid_y = 1'b0;
  endtask

  task automatic send_frame(input int sel, input y_t f[5],
                            input int maxgap);
    for (int i = 0; i < 5; i++)
      send(sel, f[i], $urandom_range(0, maxgap));
  endtask

  task automatic expect_q(input string tag, input int sel,
                          input int exp[6], input int n);
    int t = 0;
    int got[$];
    while (((sel == 0) ? q5.size() : q0.size()) < n && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (8) begin @(posedge clk); #1; end
    if (sel == 0) begin got = q5; q5.delete(); end
    else          begin got = q0; q0.delete(); end
    chk({tag, "_count"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    b5.s_valid_y = 1'b0; b5.s_data_in_y = '0;
    b0.s_valid_y = 1'b0; b0.s_data_in_y = '0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid5", b5.m_valid_x, 0);
    chk("rst_data5", b5.m_data_out_x, 0);
    chk("rst_sready5", b5.s_ready_y, 1);
    chk("rst_valid0", b0.m_valid_x, 0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // frames 1 and 2 back to back
    send_frame(0, f1, 0);
    send_frame(0, f2, 0);
    expect_q("t12", 0, '{112, 50, 87, 127, 68, 18}, 6);
    chk("t12_idle_valid", b5.m_valid_x, 0);

`ifdef CONV_POOL_RELU_EN
    send_frame(0, f3, 0);
    expect_q("t3", 0, '{0, 0, 0, 0, 0, 0}, 3);
    send_frame(1, f4, 0);
    expect_q("t4", 1, '{0, 0, 0, 0, 0, 0}, 3);
`else
    send_frame(0, f3, 0);
    expect_q("t3", 0, '{-88, -125, -4, 0, 0, 0}, 3);
    send_frame(1, f4, 0);
    expect_q("t4", 1, '{-128, -128, -128, 0, 0, 0}, 3);
`endif
    send_frame(1, f4b, 0);
    expect_q("t4b", 1, '{127, 50, 5, 0, 0, 0}, 3);

    rnd = 1'b1;
    send_frame(0, f1, 2);
    send_frame(0, f2, 2);
    expect_q("t5", 0, '{112, 50, 87, 127, 68, 18}, 6);
    rnd = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // reset with a partial frame and a stalled output
    send(0, f1[0], 0);
    send(0, f1[1], 0);
    send(0, f1[2], 0);
    rdy_fix = 1'b0;
    send(0, f1[3], 0);
    @(negedge clk);
    chk("t6_stalled", b5.m_valid_x, 1);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_valid", b5.m_valid_x, 0);
    chk("t6_rst_data", b5.m_data_out_x, 0);
    chk("t6_rst_sready", b5.s_ready_y, 1);
    rdy_fix = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    q5.delete();
    reset = 1'b1;
    @(posedge clk); #1;
    send_frame(0, f1, 0);
    expect_q("t6", 0, '{112, 50, 87, 0, 0, 0}, N_OUT_PER_FRAME);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
